// File: rtl/package_fp32.sv
// FP32 pack stage: normalise, round-to-nearest-even, pack IEEE-754 single.
// Three registered stages (capture/lzc, normalise, round/pack) with a valid/ready handshake.
module package_fp32 #(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             nj_mode,
    input  logic             s,
    input  logic [EXP_W-1:0] exp,
    input  logic [27:0]      frac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             flag_ovf,
    output logic             flag_udf,
    output logic             flag_nx
);
    localparam int W = EXP_W + 2;

    logic [3:1] vld_pipe;
    logic [3:1] en;

    // stage k loads when empty or when the stage after it is moving
    assign en[3]     = ~vld_pipe[3] | out_ready;
    assign en[2]     = ~vld_pipe[2] | en[3];
    assign en[1]     = ~vld_pipe[1] | en[2];
    assign in_ready  = en[1];
    assign out_valid = vld_pipe[3];

    // stage valid shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (en[1]) vld_pipe[1] <= in_valid;
            if (en[2]) vld_pipe[2] <= vld_pipe[1];
            if (en[3]) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // ---------------- stage 1: capture ----------------
    logic             s1, nj1;
    logic [EXP_W-1:0] e1;
    logic [27:0]      f1;

    // capture operand fields on a stage-1 transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0; nj1 <= 1'b0; e1 <= '0; f1 <= '0;
        end else if (en[1] && in_valid) begin
            s1 <= s; nj1 <= nj_mode; e1 <= exp; f1 <= frac;
        end
    end

    logic [4:0] lz1;
    logic       z1;

    // leading-zero count of the captured magnitude; highest set bit wins
    always_comb begin
        lz1 = 5'd27;
        for (int i = 0; i < 28; i++)
            if (f1[i]) lz1 = 5'(27 - i);
        z1 = (f1 == '0);
    end

    // ---------------- stage 2: normalise ----------------
    logic [W-1:0] ex1, e_n, eb_n, sh;
    logic [27:0]  m_n, lost;
    logic         st_n, den_n;

    // place the leading one at bit 26, then denormalise if the biased exponent is <= 0
    always_comb begin
        ex1   = {{2{e1[EXP_W-1]}}, e1};
        st_n  = 1'b0;
        den_n = 1'b0;
        lost  = '0;
        sh    = '0;
        if (f1[27]) begin
            m_n  = {1'b0, f1[27:1]};
            st_n = f1[0];
            e_n  = ex1 + W'(1);
        end else begin
            m_n = f1 << (lz1 - 5'd1);
            e_n = ex1 - W'(lz1) + W'(1);
        end
        eb_n = e_n + W'(127);
        if (eb_n[W-1] || eb_n == '0) begin
            sh    = W'(1) - eb_n;
            den_n = 1'b1;
            if (sh >= W'(28)) begin
                // everything falls off the bottom
                st_n = st_n | (|m_n);
                m_n  = '0;
            end else begin
                lost = m_n & ((28'd1 << sh[4:0]) - 28'd1);
                st_n = st_n | (|lost);
                m_n  = m_n >> sh[4:0];
            end
            eb_n = '0;
        end
    end

    logic         s2, nj2, z2, den2, st2;
    logic [26:0]  m2;
    logic [W-1:0] eb2;

    // normalised operand register
    always_ff @(posedge clk) begin
        if (rst) begin
            s2 <= 1'b0; nj2 <= 1'b0; z2 <= 1'b0; den2 <= 1'b0; st2 <= 1'b0;
            m2 <= '0; eb2 <= '0;
        end else if (en[2] && vld_pipe[1]) begin
            s2 <= s1; nj2 <= nj1; z2 <= z1; den2 <= den_n; st2 <= st_n;
            m2 <= m_n[26:0]; eb2 <= eb_n;
        end
    end

    // ---------------- stage 3: round and pack ----------------
    logic [23:0]  mant;
    logic [24:0]  sum;
    logic         g3, st3, inc3, nx3, den3;
    logic [W-1:0] ebr;
    logic [31:0]  res_n;
    logic         ovf_n, udf_n, nx_n;

    // RNE rounding, exponent fix-up after carry, special-case selection
    always_comb begin
        mant  = m2[26:3];
        g3    = m2[2];
        st3   = m2[1] | m2[0] | st2;
        inc3  = g3 & (st3 | mant[0]);
        sum   = {1'b0, mant} + 25'(inc3);
        nx3   = g3 | st3;
        ebr   = eb2;
        den3  = den2;
        if (sum[24]) ebr = eb2 + W'(1);
        // a denormal that rounds up to 1.0 x 2^-126 becomes the minimum normal
        if (den2 && sum[23]) begin
            ebr  = W'(1);
            den3 = 1'b0;
        end
        res_n = '0;
        ovf_n = 1'b0;
        udf_n = 1'b0;
        nx_n  = 1'b0;
        if (z2) begin
            res_n = {s2, 31'b0};
        end else if (ebr >= W'(255)) begin
            res_n = {s2, 8'hFF, 23'b0};
            ovf_n = 1'b1;
            nx_n  = 1'b1;
        end else if (den3) begin
            if (nj2) begin
                res_n = {s2, 31'b0};
                udf_n = 1'b1;
                nx_n  = 1'b1;
            end else begin
                res_n = {s2, 8'h00, sum[22:0]};
                udf_n = nx3;
                nx_n  = nx3;
            end
        end else begin
            res_n = {s2, ebr[7:0], sum[22:0]};
            nx_n  = nx3;
        end
    end

    // output register; holds while stalled by out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0; flag_ovf <= 1'b0; flag_udf <= 1'b0; flag_nx <= 1'b0;
        end else if (en[3] && vld_pipe[2]) begin
            result <= res_n; flag_ovf <= ovf_n; flag_udf <= udf_n; flag_nx <= nx_n;
        end
    end

endmodule

// File: tb/tb_package_fp32.sv
// Self-checking bench for package_fp32: vector table with a scoreboard queue,
// plus handshake sequences for latency, backpressure and mid-stream reset.
module tb_package_fp32;
    localparam int EXP_W = 10;

    logic             clk = 1'b0, rst = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic             nj_mode = 1'b0, s = 1'b0;
    logic [EXP_W-1:0] exp_i = '0;
    logic [27:0]      frac = '0;
    logic             out_valid, out_ready = 1'b1;
    logic [31:0]      result;
    logic             flag_ovf, flag_udf, flag_nx;

    package_fp32 #(.EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .nj_mode(nj_mode), .s(s), .exp(exp_i), .frac(frac),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_ovf(flag_ovf), .flag_udf(flag_udf), .flag_nx(flag_nx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        sg;
        int          ex;
        logic [27:0] fr;
        logic        nj;
        logic [31:0] res;
        logic [2:0]  fl;   // {ovf, udf, nx}
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [2:0]  fl;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    exp_t cur;
    int   errors = 0, checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic add(input string nm, input logic sg, input int ex, input logic [27:0] fr,
                       input logic nj, input logic [31:0] res, input logic [2:0] fl);
        vec_t v;
        v.nm = nm; v.sg = sg; v.ex = ex; v.fr = fr; v.nj = nj; v.res = res; v.fl = fl;
        vt.push_back(v);
    endtask

    task automatic apply(input int i);
        s       = vt[i].sg;
        exp_i   = vt[i].ex[EXP_W-1:0];
        frac    = vt[i].fr;
        nj_mode = vt[i].nj;
        cur.nm  = vt[i].nm;
        cur.res = vt[i].res;
        cur.fl  = vt[i].fl;
    endtask

    // present vector i until accepted; returns just after the accepting edge
    task automatic drive(input int i);
        bit ok = 1'b0;
        apply(i);
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout: vector %s never accepted", vt[i].nm);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got %h with nothing outstanding", result);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_result"}, result, e.res);
                    chk({e.nm, "_flags"}, {29'b0, flag_ovf, flag_udf, flag_nx}, {29'b0, e.fl});
                end
            end
            if (in_valid && in_ready) sb.push_back(cur);
        end
    end

    int lat, c0, k, nv, first, last, nstale;
    int bpi[5] = '{0, 1, 3, 4, 7};

    initial begin
        //   name          s  exp   frac          nj  result         {ovf,udf,nx}
        add("one",         0,    0, 28'h4000000, 0, 32'h3F800000, 3'b000);
        add("two",         0,    0, 28'h8000000, 0, 32'h40000000, 3'b000);
        add("lz27",        0,    0, 28'h0000001, 0, 32'h32800000, 3'b000); // 1 * 2^-26
        add("tie_even",    0,    0, 28'h4000004, 0, 32'h3F800000, 3'b001);
        add("tie_odd",     0,    0, 28'h400000C, 0, 32'h3F800002, 3'b001);
        add("ovf_pos",     0,  128, 28'h4000000, 0, 32'h7F800000, 3'b101);
        add("ovf_neg",     1,  128, 28'h4000000, 0, 32'hFF800000, 3'b101);
        add("denorm",      0, -127, 28'h4000000, 0, 32'h00400000, 3'b000);
        add("denorm_ftz",  0, -127, 28'h4000000, 1, 32'h00000000, 3'b011);
        add("neg_zero",    1,    0, 28'h0000000, 0, 32'h80000000, 3'b000);
        add("to_min_norm", 0, -127, 28'h7FFFFFF, 1, 32'h00800000, 3'b001);
        add("deep_denorm", 0, -200, 28'h4000000, 0, 32'h00000000, 3'b011);
        add("denorm_sh4",  0, -130, 28'h4000000, 0, 32'h00080000, 3'b000);
        add("round_up",    0,    3, 28'h4000006, 0, 32'h41000001, 3'b001);
        add("carry_out",   0,    0, 28'h7FFFFFC, 0, 32'h40000000, 3'b001);
        add("bit27_stky",  0,    0, 28'h8000001, 0, 32'h40000000, 3'b001);
        add("round_ovf",   0,  127, 28'h7FFFFFC, 0, 32'h7F800000, 3'b101);
        add("max_norm",    0,  127, 28'h7FFFFF8, 0, 32'h7F7FFFFF, 3'b000);
        add("neg_small",   1,  -10, 28'h4000000, 0, 32'hBA800000, 3'b000);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {29'b0, flag_ovf, flag_udf, flag_nx}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // latency: output transfer on the third edge after acceptance
        drive(0);
        lat = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (out_valid) begin lat = t; break; end
        end
        chk("latency", lat, 3);
        wait_drain();

        // full throughput pass: one vector per cycle
        c0 = cyc;
        for (int i = 0; i < vt.size(); i++) drive(i);
        chk("throughput_cycles", cyc - c0, vt.size());
        wait_drain();

        // same table under random output stalls
        fork
            begin
                for (int i = 0; i < vt.size(); i++) drive(i);
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // backpressure: five inputs offered with the output stalled
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (k < 5) begin apply(bpi[k]); in_valid = 1'b1; end
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", k, 3);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_result_held", result, vt[bpi[0]].res);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_result_stable", result, vt[bpi[0]].res);
        @(posedge clk); #1;
        out_ready = 1'b1;
        nv = 0; first = -1; last = -1;
        for (int c = 0; c < 30 && nv < 5; c++) begin
            if (k < 5) begin apply(bpi[k]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (c == 0) chk("bp_full_in_ready", 32'(in_ready), 1);
            if (in_valid && in_ready) k++;
            if (out_valid) begin
                if (first < 0) first = c;
                last = c; nv++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", k, 5);
        chk("bp_results", nv, 5);
        chk("bp_no_gaps", last - first + 1, 5);
        wait_drain();

        // reset mid-stream discards in-flight items
        out_ready = 1'b0;
        drive(2);
        drive(5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        nstale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) nstale++;
        end
        chk("rst_no_stale", nstale, 0);
        @(posedge clk); #1;

        // resumes normally after reset
        drive(9);
        drive(13);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
